// File: rtl/frame_drawer.sv
// Frame drawer: snapshots game state on a frame tick and streams erase/platform/ball pixels to a VGA adapter.
// Optional score bar on row 0 is enabled by defining FRAME_DRAWER_SCORE_BAR_EN.
module frame_drawer #(
    parameter int BALL_X    = 76,
    parameter int BALL_SIZE = 4,
    parameter int PLAT_Y    = 112,
    parameter int PLAT_W    = 32,
    parameter int PLAT_H    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  prev_ball,
    input  logic [7:0]  curr_ball,
    input  logic [2:0]  color_ball,
    input  logic [11:0] color_plats,
    input  logic [27:0] position_plats,
    input  logic [15:0] score,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] BALL_LAST = 8'(BALL_SIZE - 1);
    localparam logic [7:0] PW_LAST   = 8'(PLAT_W - 1);
    localparam logic [7:0] PH_LAST   = 8'(PLAT_H - 1);

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        PLATS,
        BALL,
        SCORE,
        FIN
    } state_t;

    state_t      state, next_state;
    logic [7:0]  cx, cy;
    logic [1:0]  plat_idx;

    logic [7:0]  snap_prev, snap_curr;
    logic [2:0]  snap_cb;
    logic [11:0] snap_cp;
    logic [27:0] snap_pos;
`ifdef FRAME_DRAWER_SCORE_BAR_EN
    logic [15:0] snap_score;
`else
    logic        unused_score;
    assign unused_score = ^score;
`endif

    logic        accept, pix_en, row_end, blk_end;
    logic [8:0]  px, py;
    logic [2:0]  pcol;
    logic [6:0]  plat_pos;
    logic [2:0]  plat_col;

    always_comb begin
        plat_pos = snap_pos[6:0];
        plat_col = snap_cp[2:0];
        case (plat_idx)
            2'd1:    begin plat_pos = snap_pos[13:7];  plat_col = snap_cp[5:3];  end
            2'd2:    begin plat_pos = snap_pos[20:14]; plat_col = snap_cp[8:6];  end
            2'd3:    begin plat_pos = snap_pos[27:21]; plat_col = snap_cp[11:9]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Addresses are formed 9 bits wide so off-screen coordinates clip instead of wrapping.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        pix_en     = 1'b0;
        row_end    = 1'b0;
        blk_end    = 1'b0;
        px         = '0;
        py         = '0;
        pcol       = '0;
        case (state)
            IDLE: begin
                // done high means the FIN cycle is still on the outputs; a tick there is dropped.
                if (start && !done) begin
                    accept     = 1'b1;
                    next_state = ERASE;
                end
            end
            ERASE: begin
                pix_en  = 1'b1;
                px      = 9'(BALL_X) + {1'b0, cx};
                py      = {1'b0, snap_prev} + {1'b0, cy};
                row_end = (cx == BALL_LAST);
                blk_end = row_end && (cy == BALL_LAST);
                if (blk_end) next_state = PLATS;
            end
            PLATS: begin
                pix_en  = 1'b1;
                px      = {2'b00, plat_pos} + {1'b0, cx};
                py      = 9'(PLAT_Y) + {1'b0, cy};
                pcol    = plat_col;
                row_end = (cx == PW_LAST);
                blk_end = row_end && (cy == PH_LAST);
                if (blk_end && plat_idx == 2'd3) next_state = BALL;
            end
            BALL: begin
                pix_en  = 1'b1;
                px      = 9'(BALL_X) + {1'b0, cx};
                py      = {1'b0, snap_curr} + {1'b0, cy};
                pcol    = snap_cb;
                row_end = (cx == BALL_LAST);
                blk_end = row_end && (cy == BALL_LAST);
`ifdef FRAME_DRAWER_SCORE_BAR_EN
                if (blk_end) next_state = SCORE;
`else
                if (blk_end) next_state = FIN;
`endif
            end
`ifdef FRAME_DRAWER_SCORE_BAR_EN
            SCORE: begin
                pix_en  = 1'b1;
                px      = {1'b0, cx};
                py      = '0;
                // cx never exceeds 159, so cx < score is the same as cx < min(score,160).
                pcol    = ({8'h00, cx} < snap_score) ? 3'b111 : 3'b000;
                row_end = (cx == 8'd159);
                blk_end = row_end;
                if (blk_end) next_state = FIN;
            end
`endif
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x         <= '0;
            y         <= '0;
            colour    <= '0;
            plot      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cx        <= '0;
            cy        <= '0;
            plat_idx  <= '0;
            snap_prev <= '0;
            snap_curr <= '0;
            snap_cb   <= '0;
            snap_cp   <= '0;
            snap_pos  <= '0;
`ifdef FRAME_DRAWER_SCORE_BAR_EN
            snap_score <= '0;
`endif
        end else begin
            done <= (state == FIN);
            plot <= 1'b0;
            if (state == FIN) busy <= 1'b0;
            if (accept) begin
                busy      <= 1'b1;
                cx        <= '0;
                cy        <= '0;
                plat_idx  <= '0;
                snap_prev <= prev_ball;
                snap_curr <= curr_ball;
                snap_cb   <= color_ball;
                snap_cp   <= color_plats;
                snap_pos  <= position_plats;
`ifdef FRAME_DRAWER_SCORE_BAR_EN
                snap_score <= score;
`endif
            end
            if (pix_en) begin
                x      <= px[7:0];
                y      <= py[6:0];
                colour <= pcol;
                plot   <= (px < 9'd160) && (py < 9'd120);
                if (!row_end) begin
                    cx <= cx + 8'd1;
                end else begin
                    cx <= '0;
                    if (blk_end) begin
                        cy <= '0;
                        if (state == PLATS) plat_idx <= plat_idx + 2'd1;
                    end else begin
                        cy <= cy + 8'd1;
                    end
                end
            end
        end
    end

endmodule
